// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round constants, key-schedule FSM
// states, the 32-bit word type and the RotWord helper.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  // Round constants for rounds 1..10 (only the leading byte is non-zero).
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Cyclic left rotation by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
// Ports:
//   data_in    - input byte
//   data_out_c - substituted byte (combinational)
module aes_sbox (
  input  logic [7:0] data_in,
  output logic [7:0] data_out_c
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_out_c = SBOX[data_in];

endmodule

// File: rtl/keyexpand.sv
// AES-128 key schedule. Latches the cipher key when start rises, derives
// round keys 1..10 one per cycle into a register file, then holds finish
// high while start stays high. round_key is a combinational read port.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - level request, held for the whole operation
//   key        - cipher key (key[127:96] is w0)
//   round_sel  - round key index 0..10
//   finish     - all round keys valid and start still high
//   round_key  - selected round key, zero unless finished and in range
module keyexpand #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [3:0]   round_sel,
  output logic         finish,
  output logic [127:0] round_key
);
  import aes_pkg::*;

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("keyexpand supports only NR = 10 (AES-128)");
  end

  localparam int unsigned NUM_RK = NR + 1;
  localparam int unsigned CNT_W  = 4;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               finish_q, finish_d;
  logic [127:0]       rk_q [NUM_RK];
  logic [127:0]       rk_d [NUM_RK];

  logic [127:0]       prev_rk;
  logic [7:0]         rcon_byte;
  word_t              rot_w3;
  word_t              sub_w;
  word_t              temp_w;
  logic [127:0]       next_rk;

  // Select the previous round key rk[cnt-1] and the round constant rcon[cnt].
  always_comb begin
    prev_rk   = '0;
    rcon_byte = '0;
    for (int i = 0; i < int'(NUM_RK) - 1; i++) begin
      if (cnt_q == CNT_W'(i + 1)) prev_rk = rk_q[i];
    end
    for (int i = 1; i <= 10; i++) begin
      if (cnt_q == CNT_W'(i)) rcon_byte = RCON[i];
    end
  end

  assign rot_w3 = rot_word(prev_rk[31:0]);

  // SubWord: one 32-bit word per cycle through four byte S-boxes.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .data_in    (rot_w3[8*b +: 8]),
      .data_out_c (sub_w[8*b +: 8])
    );
  end

  // Next round key from the previous one.
  always_comb begin
    word_t w0n, w1n, w2n, w3n;
    temp_w  = sub_w ^ {rcon_byte, 24'h0};
    w0n     = prev_rk[127:96] ^ temp_w;
    w1n     = prev_rk[95:64]  ^ w0n;
    w2n     = prev_rk[63:32]  ^ w1n;
    w3n     = prev_rk[31:0]   ^ w2n;
    next_rk = {w0n, w1n, w2n, w3n};
  end

  // Next-state, counter, register-file write and finish flag.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    finish_d = finish_q;
    rk_d     = rk_q;
    unique case (state_q)
      IDLE: begin
        finish_d = 1'b0;
        if (start) begin
          rk_d[0] = key;
          cnt_d   = CNT_W'(1);
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (!start) begin
          // Abort: partial keys stay stored but are unreadable.
          state_d  = IDLE;
          cnt_d    = '0;
          finish_d = 1'b0;
        end else begin
          for (int i = 1; i < int'(NUM_RK); i++) begin
            if (cnt_q == CNT_W'(i)) rk_d[i] = next_rk;
          end
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_W'(NR)) begin
            state_d  = DONE;
            finish_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_d  = IDLE;
          cnt_d    = '0;
          finish_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        finish_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      finish_q <= 1'b0;
      for (int i = 0; i < int'(NUM_RK); i++) rk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
      rk_q     <= rk_d;
    end
  end

  // Read port: only exposes keys once the whole schedule is complete.
  always_comb begin
    round_key = '0;
    if (finish_q) begin
      for (int i = 0; i < int'(NUM_RK); i++) begin
        if (round_sel == CNT_W'(i)) round_key = rk_q[i];
      end
    end
  end

  assign finish = finish_q;

endmodule
